// File: rtl/seven_seg_pkg.sv
// Shared constants, segment codes and FSM encoding for the 7-segment scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seven_seg_pkg;

  localparam int NUM_DIGITS  = 8;
  localparam int BCD_NIBBLES = 10;
  localparam int VALUE_W     = 32;
  localparam int BCD_W       = 4 * BCD_NIBBLES;

  // Segment codes {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Decimal nibble to active-low segment pattern; non-decimal nibbles go blank
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bin2bcd.sv
// Iterative double-dabble: 32-bit binary to 10-nibble BCD, one bit per cycle.
// Latency: start -> 32 CONVERT cycles -> 1 COMMIT cycle (done pulse, bcd valid).
// Backpressure: start is honoured only while ready (IDLE or COMMIT); caller holds it otherwise.
module bin2bcd_seq
  import seven_seg_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [VALUE_W-1:0] start_value,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [4:0]         cnt_q;
  logic               accept;

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_COMMIT);
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_COMMIT);
  assign bcd    = bcd_q;
  assign accept = start && ready;

  // Add-3 correction on every nibble that would overflow a decimal digit when doubled
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a back-to-back start from COMMIT skips IDLE entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CONVERT;
      ST_CONVERT: if (cnt_q == 5'd31) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = start ? ST_CONVERT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Shift/BCD datapath; bcd_q stays stable through COMMIT so the caller can capture it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q <= start_value;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == ST_CONVERT) begin
      bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
      shift_q <= {shift_q[VALUE_W-2:0], 1'b0};
      cnt_q   <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Binary value to 8-digit multiplexed common-anode display (optional SEVEN_SEG_LEADING_ZERO_BLANK_EN).
// Latency: load -> digits updated 34 cycles later; scan outputs lag index/digit by 1 cycle.
// Backpressure: none; loads during a conversion park in a single pending slot, newest wins.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         catodes,
  output logic [7:0]         anodes
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic                           conv_ready;
  logic                           conv_busy;
  logic                           conv_done;
  logic [BCD_W-1:0]               conv_bcd;
  logic                           conv_start;
  logic [VALUE_W-1:0]             conv_value;

  logic                           pend_vld_q;
  logic [VALUE_W-1:0]             pend_dat_q;

  logic [NUM_DIGITS-1:0][3:0]     digits_q;
  logic [NUM_DIGITS-1:0]          blank_q;
  logic [DIV_W-1:0]               div_q;
  logic [2:0]                     scan_idx_q;

  // A fresh load takes priority over the parked value since it is the newer one
  assign conv_start = conv_ready && (load || pend_vld_q);
  assign conv_value = load ? value : pend_dat_q;
  assign busy       = conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk         (clk),
    .resetn      (resetn),
    .start       (conv_start),
    .start_value (conv_value),
    .ready       (conv_ready),
    .busy        (conv_busy),
    .done        (conv_done),
    .bcd         (conv_bcd)
  );

  // Single-entry pending slot: filled by loads the converter cannot take yet
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
    end else if (conv_start) begin
      pend_vld_q <= 1'b0;
    end else if (load) begin
      pend_vld_q <= 1'b1;
      pend_dat_q <= value;
    end
  end

  // Commit the low 8 BCD digits and the overflow flag when the converter finishes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits_q <= '0;
      overflow <= 1'b0;
    end else if (conv_done) begin
      digits_q <= conv_bcd[4*NUM_DIGITS-1:0];
      overflow <= |conv_bcd[BCD_W-1:4*NUM_DIGITS];
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_d;

  // Blank every digit above the most significant non-zero one; digit 0 never blanks
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    blank_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz    = seen_nz || (conv_bcd[4*i +: 4] != 4'd0);
      blank_d[i] = !seen_nz;
    end
  end

  // Blank mask travels with the digit register so both change on the same edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blank_q <= '0;
    end else if (conv_done) begin
      blank_q <= blank_d;
    end
  end
`else
  assign blank_q = '0;
`endif

  // Refresh divider and digit index; index advances on the divider terminal count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q      <= '0;
      scan_idx_q <= '0;
    end else if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_q      <= '0;
      scan_idx_q <= scan_idx_q + 3'd1;
    end else begin
      div_q      <= div_q + DIV_W'(1);
    end
  end

  // Registered display drive; dp is always off
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      anodes  <= 8'hFF;
      catodes <= 8'hFF;
    end else begin
      anodes <= ~(8'b1 << scan_idx_q);
      if (blank_q[scan_idx_q]) begin
        catodes <= 8'hFF;
      end else begin
        catodes <= {1'b1, seg_decode(digits_q[scan_idx_q])};
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4 and a value scoreboard.
// Latency: checks conversion timing, pending handling, scan order and reset.
// Backpressure: n/a.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load;
  logic [31:0] value;
  logic        busy;
  logic        overflow;
  logic [7:0]  catodes;
  logic [7:0]  anodes;

  int errors = 0;
  int checks = 0;
  int seen5  = 0;
  bit mon5   = 1'b0;

  logic [31:0] exp_q[$];
  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [7:0]  wrap_seq [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};

  seven_seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .value    (value),
    .busy     (busy),
    .overflow (overflow),
    .catodes  (catodes),
    .anodes   (anodes)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon5 && catodes === 8'h92) seen5++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected catodes for digit i of value v (display shows v mod 10^8)
  function automatic logic [7:0] exp_cat(input logic [31:0] v, input int i);
    longint unsigned lv, p, m;
    int d;
    lv = 64'(v);
    p  = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    m = lv % 100000000;
    d = int'((m / p) % 10);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (i != 0 && m < p) return 8'hFF;
`endif
    return {1'b1, seg_tab[d]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a load; scoreboard keeps at most one in-flight value plus one pending value
  task automatic do_load(input logic [31:0] v);
    value = v;
    load  = 1'b1;
    if (exp_q.size() == 2) exp_q[1] = v;
    else exp_q.push_back(v);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 100 && busy; k++) tick();
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Walk the scan and compare every digit position against the model
  task automatic scan_all(input string tag, input logic [31:0] v);
    logic [7:0] one;
    logic [7:0] target;
    one = 8'b1;
    for (int i = 0; i < 8; i++) begin
      int n;
      n = 0;
      target = ~(one << i);
      while (anodes !== target && n < 80) begin
        tick();
        n++;
      end
      chk($sformatf("%s_an%0d", tag, i), 32'(anodes), 32'(target));
      chk($sformatf("%s_d%0d", tag, i), 32'(catodes), 32'(exp_cat(v, i)));
    end
  endtask

  // Compare whichever digit is lit right now
  task automatic chk_current(input string tag, input logic [31:0] v);
    logic [7:0] one;
    int idx;
    int found;
    one   = 8'b1;
    idx   = 0;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (anodes === ~(one << i)) begin
        idx   = i;
        found = 1;
      end
    end
    chk({tag, "_onehot"}, 32'(found), 32'd1);
    chk(tag, 32'(catodes), 32'(exp_cat(v, idx)));
  endtask

  initial begin
    logic [7:0]  cur;
    logic [31:0] v;
    int          run;
    int          j;
    bit          all_hi;

    resetn = 1'b0;
    load   = 1'b0;
    value  = '0;

    // Reset state
    #23;
    chk("rst_catodes", 32'(catodes), 32'hFF);
    chk("rst_anodes", 32'(anodes), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("first_anodes", 32'(anodes), 32'hFE);
    chk("first_catodes", 32'(catodes), 32'hC0);

    // Scan order and dwell time
    cur = anodes;
    run = 1;
    j   = 0;
    for (int k = 0; k < 60 && j < 8; k++) begin
      tick();
      if (anodes === cur) begin
        run++;
      end else begin
        chk($sformatf("wrap_an%0d", j), 32'(cur), 32'(wrap_seq[j]));
        chk($sformatf("wrap_len%0d", j), 32'(run), 32'd4);
        j++;
        cur = anodes;
        run = 1;
      end
    end
    chk("wrap_final", 32'(cur), 32'(wrap_seq[8]));
    chk("wrap_steps", 32'(j), 32'd8);

    // Conversion timing: busy in cycles 1..33, low in 34
    do_load(32'd12345678);
    tick();
    load = 1'b0;
    chk("busy_c1", 32'(busy), 32'd1);
    all_hi = 1'b1;
    repeat (32) begin
      tick();
      if (busy !== 1'b1) all_hi = 1'b0;
    end
    chk("busy_c2_33", 32'(all_hi), 32'd1);
    tick();
    chk("busy_c34", 32'(busy), 32'd0);
    v = exp_q.pop_front();
    tick();
    scan_all("conv", v);

    // Overflow set then cleared
    do_load(32'hFFFF_FFFF);
    tick();
    load = 1'b0;
    wait_idle("ovf_idle");
    chk("ovf_set", 32'(overflow), 32'd1);
    v = exp_q.pop_front();
    tick();
    scan_all("ovf", v);
    do_load(32'd7);
    tick();
    load = 1'b0;
    wait_idle("ovf2_idle");
    chk("ovf_clr", 32'(overflow), 32'd0);
    v = exp_q.pop_front();
    tick();
    scan_all("seven", v);

    // Leading digits (blanked when the feature is built in)
    do_load(32'd42);
    tick();
    load = 1'b0;
    wait_idle("lz_idle");
    v = exp_q.pop_front();
    tick();
    scan_all("lz", v);

    // Pending: 1 at cycle 0, 5 at cycle 3, 7 at cycle 4
    mon5 = 1'b1;
    do_load(32'd1);
    tick();
    load = 1'b0;
    tick();
    tick();
    do_load(32'd5);
    tick();
    do_load(32'd7);
    tick();
    load = 1'b0;
    repeat (29) tick();
    chk("pend_busy_c34", 32'(busy), 32'd1);
    tick();
    tick();
    v = exp_q.pop_front();
    chk_current("pend_first", v);
    wait_idle("pend_idle");
    v = exp_q.pop_front();
    tick();
    scan_all("pend_second", v);
    mon5 = 1'b0;
    chk("pend_no_five", 32'(seen5), 32'd0);

    // Reset mid-conversion discards everything
    do_load(32'd99);
    tick();
    load = 1'b0;
    repeat (9) tick();
    resetn = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_catodes", 32'(catodes), 32'hFF);
    chk("mid_rst_anodes", 32'(anodes), 32'hFF);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (50) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    scan_all("post_rst", 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream consumer of the system's SHOW_IN_DISPLAYS write (the 0x1000_0000 MMIO store that drives `num_to_display` and `out_byte_en`).
- Converts the 32-bit binary value to decimal with a sequential double-dabble.
- Time-multiplexes the low 8 decimal digits onto the Nexys 4 DDR 8-digit common-anode 7-segment display.
- Drives the system's `catodes` and `anodes` outputs.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- load  input  1  one-cycle strobe: capture value (tied to out_byte_en)
- value  input  32  unsigned binary number to show (num_to_display)
- busy  output  1  conversion in progress
- overflow  output  1  last committed value > 99_999_999
- catodes  output  8  active-low segments {dp,g,f,e,d,c,b,a}
- anodes  output  8  active-low digit enables, bit 0 = rightmost digit

Behaviour:
- Clocking and reset: single clock `clk`; reset is asynchronous and active-low on `resetn`.
- Reset values:
  - catodes=8'hFF, anodes=8'hFF, busy=0, overflow=0.
  - Digit register = all 0; pending flag = 0; scan index = 0; divider = 0; FSM = IDLE.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - On load: shift reg <= value, 40-bit BCD reg <= 0, bit counter <= 0, go to CONVERT.
  - busy is 1 from the next cycle.
- CONVERT, one bit per cycle:
  - Each of the 10 BCD nibbles >= 5 gets +3.
  - Then {bcd, shift} shifts left by 1.
  - After 32 cycles go to COMMIT.
- COMMIT, one cycle:
  - Digit register <= BCD nibbles 7..0.
  - overflow <= |BCD nibbles 9..8.
  - If the pending flag is set, start a conversion of the pending value (go to CONVERT, clear pending); else go to IDLE.
- Latency: load at cycle 0 -> busy high in cycles 1..33 -> digit register and overflow updated at the end of cycle 33 -> busy low in cycle 34 (if nothing is pending).
- load while busy (CONVERT or COMMIT): value is stored in a single-entry pending register; a newer load overwrites an older pending one.
- Scanning:
  - Divider counts 0..REFRESH_DIV-1.
  - At the terminal count the index increments, wrapping 7 -> 0.
  - Every cycle, registered: anodes <= ~(8'b1 << index); catodes <= {1'b1, seg(digit[index])}.
  - Outputs therefore lag index or digit changes by exactly 1 cycle.
  - Scanning continues during conversion and shows the previous digits (no flicker or blanking).
- Segment codes (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other nibble -> 1111111 (blank). DP is always off (1).
- Overflow: the display shows value mod 10^8; overflow holds until the next COMMIT.
- Reset mid-conversion: everything returns to reset values immediately and the pending value is discarded.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant non-zero digit show catodes=8'hFF while their anode is still driven.
  - Digit 0 is always shown, so value 0 displays a single "0".
  - The blank mask is computed at COMMIT and registered with the digit register.
- Undefined: all 8 digits are shown, including leading zeros.

Decomposition:
- Shared package/include seven_seg_pkg:
  - NUM_DIGITS=8, BCD_NIBBLES=10, VALUE_W=32.
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - FSM state encodings ST_IDLE/ST_CONVERT/ST_COMMIT.
- One sub-module, bin2bcd_seq: the iterative double-dabble with start/done handshake.
  - done is a one-cycle pulse equal to the COMMIT cycle.
  - Outputs the 40-bit BCD result.
  - The top level keeps the pending register, digit register, divider and scan logic.

Test Plan (bench uses REFRESH_DIV=4):
- Reset: hold resetn=0 -> catodes=8'hFF, anodes=8'hFF, busy=0, overflow=0; release -> anodes sequence 8'hFE (index 0) with catodes=8'hC0 ("0").
- Conversion timing: load value=12345678 at cycle 0 -> busy=1 in cycles 1..33, busy=0 at cycle 34 -> index 0 shows 8'h80 ("8"), index 7 shows 8'hF9 ("1").
- Overflow: load 32'hFFFF_FFFF (4294967295) -> overflow=1, digits 94967295. Then load 7 -> overflow=0.
- Pending: load 1 at cycle 0, load 5 at cycle 3, load 7 at cycle 4:
  - commit shows 1;
  - busy stays high, a second conversion runs and commits 7;
  - 5 never appears.
- Scan wrap: after reset, anodes step FE,FD,FB,F7,EF,DF,BF,7F,FE, each held exactly 4 cycles.
- Reset mid-conversion: load 99 then resetn=0 at cycle 10 -> immediate reset values, no later commit. With SEVEN_SEG_LEADING_ZERO_BLANK_EN, load 42 -> digits 7..2 show 8'hFF; digit 1 shows "4" (8'h99), digit 0 shows "2" (8'hA4).
